// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 ciphertext streaming path.
// Provides the default message length, the nibble count derived from it,
// and the state enumeration used by ciphertext_streamer.
package a51_pkg;

    localparam int MSG_BITS_DEF  = 128;
    localparam int NIB_COUNT_DEF = MSG_BITS_DEF / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_XOR,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ciphertext_streamer_if.sv
// Bundle of the keystream, message, nibble-handshake and status signals of
// ciphertext_streamer.
//   master : the environment side (keygen, message register, LCD writer)
//   slave  : the streamer itself
//   clear, ks_valid, ks_bit, ks_done, msg, nib_ready : master -> slave
//   nib_out, nib_valid, busy, done, short_err        : slave -> master
interface ciphertext_streamer_if #(
    parameter int MSG_BITS = a51_pkg::MSG_BITS_DEF
) ();

    logic                clear;
    logic                ks_valid;
    logic                ks_bit;
    logic                ks_done;
    logic [MSG_BITS-1:0] msg;
    logic                nib_ready;
    logic [3:0]          nib_out;
    logic                nib_valid;
    logic                busy;
    logic                done;
    logic                short_err;

    modport master (
        output clear, ks_valid, ks_bit, ks_done, msg, nib_ready,
        input  nib_out, nib_valid, busy, done, short_err
    );

    modport slave (
        input  clear, ks_valid, ks_bit, ks_done, msg, nib_ready,
        output nib_out, nib_valid, busy, done, short_err
    );

endinterface

// File: rtl/nibble_mux.sv
// NIB_COUNT:1 selector of 4-bit nibbles, MSB nibble at index 0.
//   data : packed nibbles, nibble 0 occupies the top four bits
//   idx  : nibble index
//   nib  : selected nibble (0 for an out-of-range index)
module nibble_mux import a51_pkg::*; #(
    parameter int NIB_COUNT = NIB_COUNT_DEF,
    parameter int IDX_W     = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1
) (
    input  logic [4*NIB_COUNT-1:0] data,
    input  logic [IDX_W-1:0]       idx,
    output logic [3:0]             nib
);

    always_comb begin
        nib = '0;
        for (int unsigned i = 0; i < NIB_COUNT; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = data[4*(NIB_COUNT-1-i) +: 4];
            end
        end
    end

endmodule

// File: rtl/ciphertext_streamer.sv
// Collects MSG_BITS keystream bits from an A5/1 keygen, XORs them with the
// message register once, then streams the ciphertext out as hex nibbles
// (MSB nibble first) over a valid/ready handshake.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of ciphertext_streamer_if
//                (keystream in, message in, nibble handshake, status out)
module ciphertext_streamer import a51_pkg::*; #(
    parameter int MSG_BITS  = MSG_BITS_DEF,
    parameter int NIB_COUNT = MSG_BITS / 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ciphertext_streamer_if.slave  bus
);

    localparam int CNT_W = $clog2(MSG_BITS + 1);
    localparam int IDX_W = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MSG_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_COUNT - 1);

    state_e              state_q, state_d;
    logic [MSG_BITS-1:0] ks_q, ks_d;
    logic [MSG_BITS-1:0] ct_q, ct_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                short_err_q, short_err_d;
    logic                nib_valid_q, nib_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          nib_w;

    always_comb begin
        state_d     = state_q;
        ks_d        = ks_q;
        ct_d        = ct_q;
        count_d     = count_q;
        idx_d       = idx_q;
        short_err_d = short_err_q;

        if (bus.clear) begin
            // ct is deliberately kept so the last ciphertext stays readable.
            state_d     = ST_IDLE;
            ks_d        = '0;
            count_d     = '0;
            idx_d       = '0;
            short_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ks_valid) begin
                        ks_d    = {ks_q[MSG_BITS-2:0], bus.ks_bit};
                        count_d = CNT_W'(1);
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.ks_valid) begin
                        ks_d = {ks_q[MSG_BITS-2:0], bus.ks_bit};
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        if (count_q == CNT_LAST) begin
                            state_d = ST_XOR;
                        end
                    end else if (bus.ks_done) begin
                        // Short keystream: unfilled MSBs stay zero.
                        short_err_d = 1'b1;
                        state_d     = ST_XOR;
                    end
                end
                ST_XOR: begin
                    ct_d    = ks_q ^ bus.msg;
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
                ST_EMIT: begin
                    // nib_valid is high for the whole of EMIT, so ready alone
                    // completes the handshake here.
                    if (bus.nib_ready) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state.
        nib_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d == ST_COLLECT) || (state_d == ST_XOR) ||
                      (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ks_q        <= '0;
            ct_q        <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            short_err_q <= 1'b0;
            nib_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ks_q        <= ks_d;
            ct_q        <= ct_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            short_err_q <= short_err_d;
            nib_valid_q <= nib_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    nibble_mux #(
        .NIB_COUNT (NIB_COUNT),
        .IDX_W     (IDX_W)
    ) u_nibble_mux (
        .data (ct_q),
        .idx  (idx_q),
        .nib  (nib_w)
    );

    assign bus.nib_out   = nib_w;
    assign bus.nib_valid = nib_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.short_err = short_err_q;

endmodule

// File: tb/tb_ciphertext_streamer.sv
// Self-checking bench for ciphertext_streamer: directed table of keystream
// patterns with hand-derived ciphertexts, backpressure and mid-run reset
// sequences, and randomized streams checked against a positional model.
module tb_ciphertext_streamer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   stim[$];

    ciphertext_streamer_if #(.MSG_BITS(128)) bus ();

    ciphertext_streamer #(
        .MSG_BITS  (128),
        .NIB_COUNT (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           pat;
        int           nbits;
        logic [127:0] msg;
        logic [127:0] exp_ct;
        bit           exp_short;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // pat 0: all ones, 1: alternating from 1, 2: 128 zeros then ones, 3: random
    task automatic build(input int pat, input int n);
        stim.delete();
        for (int j = 0; j < n; j++) begin
            case (pat)
                0:       stim.push_back(1'b1);
                1:       stim.push_back(j % 2 == 0);
                2:       stim.push_back(j >= 128);
                default: stim.push_back(1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    // First accepted bit is the most significant of the bits actually taken.
    function automatic logic [127:0] model_ct(input logic [127:0] m);
        logic [127:0] ks;
        int n;
        ks = '0;
        n = (stim.size() < 128) ? stim.size() : 128;
        for (int j = 0; j < n; j++) ks[n-1-j] = stim[j];
        return ks ^ m;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_clear(input logic [3:0] exp_nib0);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check("clear_done", 128'(bus.done), 128'(0));
        check("clear_busy", 128'(bus.busy), 128'(0));
        check("clear_short", 128'(bus.short_err), 128'(0));
        check("clear_ct_kept", 128'(bus.nib_out), 128'(exp_nib0));
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall 5 cycles at idx 3,
    // 3: reset (with clear and ks_valid) after 10 handshakes.
    task automatic run_msg(input string name, input int mode, input bit gaps,
                           input logic [127:0] exp_ct, output logic [127:0] got_ct);
        int bi = 0, it = 0, term = -1, first_v = -1, first_hs = -1, last_hs = -1;
        int stall = 0, cnt = 0;
        bit finished = 0;
        logic [3:0] exp3;
        logic [127:0] e;
        e = exp_ct;
        exp3 = e[115:112];
        got_ct = '0;
        while (it < 2000) begin
            if (mode == 3 && cnt == 10) begin
                reset = 1'b1; bus.clear = 1'b1; bus.ks_valid = 1'b1; bus.ks_bit = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0; bus.clear = 1'b0; bus.ks_valid = 1'b0;
                check({name, " rst_valid"}, 128'(bus.nib_valid), 128'(0));
                check({name, " rst_busy"}, 128'(bus.busy), 128'(0));
                check({name, " rst_done"}, 128'(bus.done), 128'(0));
                check({name, " rst_nib"}, 128'(bus.nib_out), 128'(0));
                finished = 1;
                break;
            end
            if (bus.done) begin
                finished = 1;
                break;
            end
            if (bus.nib_valid && first_v < 0) first_v = it;
            bus.ks_valid = 1'b0; bus.ks_bit = 1'b0; bus.ks_done = 1'b0;
            if (bi < stim.size()) begin
                if (!gaps || $urandom_range(0, 3) != 0) begin
                    bus.ks_valid = 1'b1;
                    bus.ks_bit = stim[bi];
                    if (bi == 127) term = it;
                    bi++;
                end
            end else if (stim.size() < 128) begin
                bus.ks_done = 1'b1;
                if (term < 0) term = it;
            end
            case (mode)
                1:       bus.nib_ready = 1'($urandom_range(0, 1));
                2:       bus.nib_ready = !(cnt == 3 && stall < 5);
                default: bus.nib_ready = 1'b1;
            endcase
            if (mode == 2 && cnt == 3 && stall < 5) begin
                check({name, " stall_valid"}, 128'(bus.nib_valid), 128'(1));
                check({name, " stall_nib"}, 128'(bus.nib_out), 128'(exp3));
                stall++;
            end
            if (bus.nib_valid && bus.nib_ready) begin
                got_ct = {got_ct[123:0], bus.nib_out};
                if (first_hs < 0) first_hs = it;
                last_hs = it;
                cnt++;
            end
            @(posedge clk);
            #1;
            it++;
        end
        bus.ks_valid = 1'b0; bus.ks_done = 1'b0; bus.nib_ready = 1'b0;
        check({name, " finished"}, 128'(finished), 128'(1));
        if (mode != 3) begin
            check({name, " latency"}, 128'(first_v - term), 128'(2));
            check({name, " count"}, 128'(cnt), 128'(32));
            check({name, " done_valid"}, 128'(bus.nib_valid), 128'(0));
            check({name, " done_busy"}, 128'(bus.busy), 128'(0));
            if (mode == 0) check({name, " back2back"}, 128'(last_hs - first_hs), 128'(31));
        end
    endtask

    initial begin
        logic [127:0] got, exp, m;
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.clear = 1'b0; bus.ks_valid = 1'b0; bus.ks_bit = 1'b0;
        bus.ks_done = 1'b0; bus.nib_ready = 1'b0; bus.msg = '0;

        tbl[0] = '{"all_ones",   0, 128, 128'h0, {32{4'hF}}, 1'b0};
        tbl[1] = '{"alternate",  1, 128, 128'h0123456789ABCDEF0123456789ABCDEF,
                   128'hAB89EFCD23016745AB89EFCD23016745, 1'b0};
        tbl[2] = '{"short100",   0, 100, 128'h0, {28'h0, {25{4'hF}}}, 1'b1};
        tbl[3] = '{"extra130",   2, 130, 128'h0, 128'h0, 1'b0};
        tbl[4] = '{"short1",     0, 1,   128'h0, 128'h1, 1'b1};
        tbl[5] = '{"short127",   0, 127, 128'hFFFF0000FFFF0000FFFF0000FFFF0000,
                   128'h8000FFFF0000FFFF0000FFFF0000FFFF, 1'b1};

        do_reset();
        check("reset_nib", 128'(bus.nib_out), 128'(0));
        check("reset_valid", 128'(bus.nib_valid), 128'(0));
        check("reset_busy", 128'(bus.busy), 128'(0));
        check("reset_done", 128'(bus.done), 128'(0));
        check("reset_short", 128'(bus.short_err), 128'(0));

        for (int i = 0; i < 6; i++) begin
            build(tbl[i].pat, tbl[i].nbits);
            bus.msg = tbl[i].msg;
            run_msg(tbl[i].name, 0, 1'b0, tbl[i].exp_ct, got);
            check({tbl[i].name, " ct"}, got, tbl[i].exp_ct);
            check({tbl[i].name, " short"}, 128'(bus.short_err), 128'(tbl[i].exp_short));
            check({tbl[i].name, " done"}, 128'(bus.done), 128'(1));
            exp = tbl[i].exp_ct;
            do_clear(exp[127:124]);
        end

        // Backpressure at nibble index 3.
        build(0, 128);
        bus.msg = 128'h0123456789ABCDEF0123456789ABCDEF;
        exp = 128'hFEDCBA9876543210FEDCBA9876543210;
        run_msg("stall", 2, 1'b0, exp, got);
        check("stall ct", got, exp);
        do_clear(exp[127:124]);

        // Reset after 10 handshakes, then a fresh full stream.
        build(3, 128);
        bus.msg = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_msg("midreset", 3, 1'b0, model_ct(bus.msg), got);
        build(3, 128);
        bus.msg = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp = model_ct(bus.msg);
        run_msg("after_reset", 0, 1'b0, exp, got);
        check("after_reset ct", got, exp);
        check("after_reset short", 128'(bus.short_err), 128'(0));

        for (int r = 0; r < 10; r++) begin
            do_clear(exp[127:124]);
            n = ($urandom_range(0, 1) == 1) ? $urandom_range(128, 131) : $urandom_range(1, 127);
            build(3, n);
            m = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.msg = m;
            exp = model_ct(m);
            run_msg($sformatf("rand%0d", r), 1, 1'b1, exp, got);
            check($sformatf("rand%0d ct", r), got, exp);
            check($sformatf("rand%0d short", r), 128'(bus.short_err), 128'(n < 128));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
